// File: rtl/two_bit_slice_sequencer.sv
// two_bit_slice_sequencer
//   Computes a WIDTH-bit add with carry by reusing one external 2-bit ripple-adder slice
//   over WIDTH/2 cycles, least significant digit first.
//
//   Ports:
//     clk, rst                  clock; synchronous active-high reset
//     in_valid/in_ready         operand handshake (in_a, in_b, in_cin)
//     slice_a/b/cin             digit and carry driven to the shared slice (zero outside RUN)
//     slice_sum/cout            combinational result returned by the slice
//     out_valid/out_ready       result handshake (out_sum, out_cout, out_ovf; zero unless valid)
//     busy                      high while an operation is running or awaiting hand-off
module two_bit_slice_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_cin,
    input  logic [1:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned Digits = WIDTH / 2;
    localparam int unsigned IdxW   = (Digits > 1) ? $clog2(Digits) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Digits - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    // Bit offset of the current digit; shifts keep the digit select width-agnostic.
    logic [IdxW:0]    shamt;
    logic [WIDTH-1:0] a_sh, b_sh;

    assign shamt    = {idx_q, 1'b0};
    assign a_sh     = a_q >> shamt;
    assign b_sh     = b_q >> shamt;
    assign in_ready = (state_q == StIdle) && !rst;
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        a_d       = a_q;
        b_d       = b_q;
        slice_a   = 2'b00;
        slice_b   = 2'b00;
        slice_cin = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        out_ovf   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                slice_a   = a_sh[1:0];
                slice_b   = b_sh[1:0];
                slice_cin = carry_q;
                sum_d     = (sum_q & ~(WIDTH'(2'b11) << shamt))
                          | (WIDTH'(slice_sum) << shamt);
                carry_d   = slice_cout;
                if (idx_q == LastIdx) begin
                    // idx parks on the last digit; it is cleared on the way back to IDLE.
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                out_sum   = sum_q;
                out_cout  = carry_q;
                out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: tb/tb_two_bit_slice_sequencer.sv
// tb_two_bit_slice_sequencer
//   Directed bench for two_bit_slice_sequencer (WIDTH=8) with a behavioural 2-bit adder slice.
module tb_two_bit_slice_sequencer;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [1:0]   slice_a;
    logic [1:0]   slice_b;
    logic         slice_cin;
    logic [1:0]   slice_sum;
    logic         slice_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External adder slice.
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {2'b00, slice_cin};

    two_bit_slice_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Carry entering digit k, from plain integer arithmetic on the operands.
    function automatic logic digit_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input int k);
        int mask;
        int tot;
        mask = (1 << (2 * k)) - 1;
        tot  = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
        return logic'((tot >> (2 * k)) & 1);
    endfunction

    // One complete operation; hold = cycles of out_ready=0 in DONE before release.
    task automatic do_op(input vec_t v, input int hold);
        int       n;
        int       k;
        logic [W-1:0] s_sum;
        logic     s_cout;
        logic     s_ovf;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_cin = v.cin; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        // Accept edge has passed; perturb inputs to show they are not re-sampled.
        in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b; in_cin = ~v.cin;
        k = 0;
        while (!out_valid && k < 20) begin
            if (k < N) begin
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_in_ready", 32'(in_ready), 32'd0);
                chk("slice_a", 32'(slice_a), 32'((v.a >> (2 * k)) & 3));
                chk("slice_b", 32'(slice_b), 32'((v.b >> (2 * k)) & 3));
                chk("slice_cin", 32'(slice_cin), 32'(digit_carry(v.a, v.b, v.cin, k)));
            end
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(N));
        chk("out_sum", 32'(out_sum), 32'(v.sum));
        chk("out_cout", 32'(out_cout), 32'(v.cout));
        chk("out_ovf", 32'(out_ovf), 32'(v.ovf));
        chk("done_slice_a", 32'(slice_a), 32'd0);
        s_sum = out_sum; s_cout = out_cout; s_ovf = out_ovf;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", 32'(out_sum), 32'(s_sum));
            chk("hold_cout_ovf", 32'({s_cout, s_ovf}), 32'({out_cout, out_ovf}));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_sum_zero", 32'({out_sum, out_cout, out_ovf}), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int acc[3];
        int n;
        //            a      b      cin   sum    cout  ovf
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hC3, 8'hE1, 1'b0, 8'hA4, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{8'h9C, 8'h9C, 1'b1, 8'h39, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_cin = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outputs", 32'({out_sum, out_cout, out_ovf}), 32'd0);
        chk("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Table-driven operations (T1..T3 and extras).
        for (int i = 0; i < 9; i++) do_op(vecs[i], 0);

        // T4: backpressure in DONE.
        do_op(vecs[0], 5);

        // T5: reset on the second RUN cycle.
        @(negedge clk);
        in_a = 8'h5A; in_b = 8'h3C; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);                // accept edge passed, RUN cycle 1
        in_valid = 1'b0;
        chk("t5_busy_run", 32'(busy), 32'd1);
        @(negedge clk);                // RUN cycle 2
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        chk("t5_in_ready_in_rst", 32'(in_ready), 32'd0);
        chk("t5_slice_zero", 32'({slice_a, slice_b, slice_cin}), 32'd0);
        rst = 1'b0;
        #1;
        chk("t5_in_ready_after", 32'(in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("t5_no_out_valid", 32'(n), 32'd0);
        do_op(vecs[3], 0);

        // T6: in_valid held high across three back-to-back operations.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_a = vecs[4 + j].a; in_b = vecs[4 + j].b; in_cin = vecs[4 + j].cin;
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("t6_accept_wait", 32'(in_ready), 32'd1);
            acc[j] = cyc;
            @(negedge clk);
            if (j < 2) begin
                in_a = vecs[5 + j].a; in_b = vecs[5 + j].b; in_cin = vecs[5 + j].cin;
            end
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_out_valid", 32'(out_valid), 32'd1);
            chk("t6_sum", 32'({out_cout, out_sum}), 32'({vecs[4 + j].cout, vecs[4 + j].sum}));
            chk("t6_ovf", 32'(out_ovf), 32'(vecs[4 + j].ovf));
            if (j == 2) in_valid = 1'b0;
        end
        chk("t6_spacing_01", 32'(acc[1] - acc[0]), 32'(N + 2));
        chk("t6_spacing_12", 32'(acc[2] - acc[1]), 32'(N + 2));
        @(negedge clk);
        out_ready = 1'b0;
        chk("t6_final_idle", 32'({busy, out_valid}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
